// File: rtl/ex_mem_stage.sv
// ex_mem_stage
//   EX -> MEM pipeline register with a one-entry skid buffer. Captures the ALU
//   result, store data, destination register, memory/register-write controls
//   and the resolved branch decision. Two entries can be held at most: OUT
//   (presented on the outputs) and SKID (overflow while OUT is stalled).
//   in_ready is derived purely from registered state, so there is no
//   combinational path from out_ready to in_ready.
//
// Ports
//   clk, reset                 clock, async active-high reset
//   in_valid / in_ready        upstream (EX) handshake
//   alu_result, zero_flag,
//   alu_op                     ALU outputs; alu_op 4'b0010 selects BNE sense
//   rt_data, rd_addr,
//   branch_target              store data, destination register, branch target
//   mem_read, mem_write,
//   reg_write, branch          control bits from decode
//   flush                      synchronous discard of both held entries
//   out_valid / out_ready      downstream (MEM) handshake
//   out_result, out_store_data,
//   out_rd, out_mem_read,
//   out_mem_write,
//   out_reg_write              OUT entry fields
//   branch_taken, branch_pc    resolved branch of the OUT entry
module ex_mem_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              zero_flag,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] branch_target,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              branch,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [4:0]        out_rd,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_reg_write,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_pc
);

  localparam logic [3:0] ALU_OP_BNE = 4'b0010;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [DATA_W-1:0] pc;
    logic [4:0]        rd;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              taken;
  } entry_t;

  entry_t out_q;
  entry_t skid_q;
  logic   out_valid_q;
  logic   skid_valid_q;

  entry_t in_entry;
  logic   accept;
  logic   drain;

  // Branch is resolved here so MEM sees a single taken bit; BNE inverts the
  // sense of the zero flag. Writes to r0 are suppressed at capture.
  always_comb begin
    in_entry            = '0;
    in_entry.result     = alu_result;
    in_entry.store_data = rt_data;
    in_entry.pc         = branch_target;
    in_entry.rd         = rd_addr;
    in_entry.mem_read   = mem_read;
    in_entry.mem_write  = mem_write;
    in_entry.reg_write  = reg_write & (rd_addr != 5'd0);
    in_entry.taken      = branch & ((alu_op == ALU_OP_BNE) ? ~zero_flag : zero_flag);
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || drain) begin
      // OUT is free this edge: refill from SKID first to keep FIFO order.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= accept;
        if (accept) begin
          skid_q <= in_entry;
        end
      end else if (accept) begin
        out_q       <= in_entry;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      // OUT stalled: the new entry parks in SKID and in_ready drops.
      skid_q       <= in_entry;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_result     = out_q.result;
  assign out_store_data = out_q.store_data;
  assign out_rd         = out_q.rd;
  assign branch_pc      = out_q.pc;
  // Control strobes are qualified so stale bits never leak out after a flush.
  assign out_mem_read   = out_valid_q & out_q.mem_read;
  assign out_mem_write  = out_valid_q & out_q.mem_write;
  assign out_reg_write  = out_valid_q & out_q.reg_write;
  assign branch_taken   = out_valid_q & out_q.taken;

endmodule
